apb_master_q: RTL and testbench
===============================

APB_MASTER_Q -- requirements
Module: apb_master_q

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning APB data width (multiple of 8).
REQ-003 SHALL have parameter DEPTH, default 4, meaning command queue entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning max ACCESS cycles without pready_i before abort.
REQ-005 SHALL have port: clk  input  1  single clock, rising edge.
REQ-006 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port: cmd_valid_i  input  1  command offered.
REQ-008 SHALL have port: cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-009 SHALL have port: cmd_write_i  input  1  1=write, 0=read.
REQ-010 SHALL have port: cmd_addr_i  input  ADDR_W  target address.
REQ-011 SHALL have port: cmd_wdata_i  input  DATA_W  write data.
REQ-012 SHALL have port: cmd_strb_i  input  DATA_W/8  write byte strobes.
REQ-013 SHALL have port: rsp_valid_o  output  1  one-cycle completion pulse.
REQ-014 SHALL have port: rsp_rdata_o  output  DATA_W  read data (0 for writes/errors).
REQ-015 SHALL have port: rsp_err_o  output  1  pslverr_i or timeout.
REQ-016 SHALL have ports: psel_o, penable_o, pwrite_o  output  1; paddr_o  output  ADDR_W; pwdata_o  output  DATA_W; pstrb_o  output  DATA_W/8.
REQ-017 SHALL have ports: pready_i, pslverr_i  input  1; prdata_i  input  DATA_W.

Function
REQ-018 Commands SHALL be pushed into a FIFO on cmd_valid_i && cmd_ready_o; cmd_ready_o SHALL equal !full (no same-cycle pop bypass when full).
REQ-019 FSM states IDLE, SETUP, ACCESS; IDLE->SETUP when FIFO non-empty; SETUP->ACCESS unconditionally.
REQ-020 ACCESS with pready_i: pop FIFO head; go to SETUP if another entry remains after the pop, else IDLE (back-to-back transfers, no idle gap).
REQ-021 ACCESS without pready_i: stay; per-transfer wait counter increments; counter cleared on entry to SETUP.
REQ-022 When the wait counter reaches TIMEOUT-1 without pready_i, the transfer SHALL abort: pop, go to IDLE, respond with rsp_err_o=1.
REQ-023 psel_o=1 in SETUP/ACCESS; penable_o=1 only in ACCESS; paddr_o/pwrite_o/pwdata_o/pstrb_o driven from FIFO head and stable across SETUP and ACCESS.
REQ-024 In IDLE all APB outputs SHALL be 0; pstrb_o SHALL be 0 for reads.
REQ-025 rsp_valid_o SHALL pulse exactly one cycle after completion (pready_i in ACCESS or timeout) with registered rsp_rdata_o and rsp_err_o.
REQ-026 rsp_rdata_o SHALL capture prdata_i for successful reads; 0 for writes, pslverr_i reads and timeouts.
REQ-027 rsp_err_o SHALL equal pslverr_i sampled with pready_i, or 1 on timeout.
REQ-028 Responses SHALL be returned in command order; no response backpressure.
REQ-029 Simultaneous push and pop SHALL keep occupancy unchanged; pointers SHALL wrap modulo DEPTH.

Reset
REQ-030 On reset: state=IDLE, FIFO empty, wait counter=0, all outputs 0 except cmd_ready_o=1.
REQ-031 Reset asserted mid-transfer SHALL immediately deassert psel_o/penable_o and discard queued commands without a response.

Structure
REQ-032 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the command struct (write, addr, wdata, strb), parametrised via ADDR_W/DATA_W defaults.
REQ-033 The queue SHALL be a sub-module apb_cmd_fifo (DEPTH, payload width) with push/pop/full/empty.

Verification
REQ-034 Read 0xDEAD_CAFE, pready_i after 3 waits, prdata_i=0x0000_0005 -> SETUP 1 cycle, ACCESS 4 cycles, rsp_valid_o next cycle, rdata=5, err=0.
REQ-035 Write 0xDEAD_CAFE data 0x6 strb 0xF, pready_i immediate -> psel_o 2 cycles, pwrite_o=1, pwdata_o=6, rsp err=0 rdata=0.
REQ-036 Push 5 commands back-to-back with pready_i held low (DEPTH=4) -> cmd_ready_o low after 4th push; 5th accepted one cycle after first pop.
REQ-037 pready_i never asserted -> after 16 ACCESS cycles abort, psel_o=0, rsp_err_o=1, next command starts.
REQ-038 Read with pslverr_i=1 on pready_i -> rsp_err_o=1, rsp_rdata_o=0.
REQ-039 Reset asserted in ACCESS with 2 queued -> psel_o/penable_o=0 same cycle, no rsp_valid_o, cmd_ready_o=1 after release.

Source files
------------

// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_pkg
// Description : Shared types for the queued APB master: FSM states and the
//               command record carried through the command queue.
// Revision    : 1.0 - initial release
// ============================================================================
package apb_pkg;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic                      write;
        logic [APB_ADDR_W-1:0]     addr;
        logic [APB_DATA_W-1:0]     wdata;
        logic [APB_DATA_W/8-1:0]   strb;
    } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : apb_cmd_fifo
// Description : Power-of-two deep synchronous FIFO holding APB commands.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_full     = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (c_PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_q.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_q
// Description : APB master with a command queue, wait-state timeout and an
//               in-order single-cycle response pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_q
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic                 cmd_write_i,
    input  logic [ADDR_W-1:0]    cmd_addr_i,
    input  logic [DATA_W-1:0]    cmd_wdata_i,
    input  logic [DATA_W/8-1:0]  cmd_strb_i,
    output logic                 rsp_valid_o,
    output logic [DATA_W-1:0]    rsp_rdata_o,
    output logic                 rsp_err_o,
    output logic                 psel_o,
    output logic                 penable_o,
    output logic                 pwrite_o,
    output logic [ADDR_W-1:0]    paddr_o,
    output logic [DATA_W-1:0]    pwdata_o,
    output logic [DATA_W/8-1:0]  pstrb_o,
    input  logic                 pready_i,
    input  logic                 pslverr_i,
    input  logic [DATA_W-1:0]    prdata_i
);

    localparam int c_STRB_W = DATA_W / 8;
    localparam int c_CMD_W  = 1 + ADDR_W + DATA_W + c_STRB_W;
    localparam int c_WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH) + 1;

    apb_state_t          r_state;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_psel;
    logic                r_penable;
    logic                r_rsp_valid;
    logic                r_rsp_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic [c_CMD_W-1:0]  w_cmd_in;
    logic [c_CMD_W-1:0]  w_head;
    logic                w_head_write;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_wdata;
    logic [c_STRB_W-1:0] w_head_strb;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    logic                w_push;
    logic                w_timeout;
    logic                w_done;
    logic                w_more;

    assign w_cmd_in     = {cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i};
    assign w_head_write = w_head[c_CMD_W-1];
    assign w_head_addr  = w_head[c_CMD_W-2 -: ADDR_W];
    assign w_head_wdata = w_head[DATA_W+c_STRB_W-1 -: DATA_W];
    assign w_head_strb  = w_head[c_STRB_W-1:0];

    assign w_push      = cmd_valid_i && !w_full;
    assign cmd_ready_o = !w_full;

    assign w_timeout = (r_state == ACCESS) && !pready_i &&
                       (r_wait == c_WAIT_W'(TIMEOUT - 1));
    assign w_done    = (r_state == ACCESS) && (pready_i || w_timeout);
    // Occupancy after this edge: the head leaves, a same-cycle push arrives.
    assign w_more    = (w_count > c_CNT_W'(1)) || w_push;

    apb_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_CMD_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (w_cmd_in),
        .i_pop       (w_done),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_wait      <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_done;
            r_rsp_err   <= w_done && (!pready_i || pslverr_i);
            r_rsp_rdata <= (w_done && pready_i && !pslverr_i && !w_head_write)
                           ? prdata_i : '0;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_wait    <= '0;
                    end
                end
                SETUP: begin
                    r_state   <= ACCESS;
                    r_psel    <= 1'b1;
                    r_penable <= 1'b1;
                end
                ACCESS: begin
                    if (pready_i && w_more) begin
                        r_state   <= SETUP;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_wait    <= '0;
                    end else if (w_done) begin
                        r_state   <= IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign psel_o      = r_psel;
    assign penable_o   = r_penable;
    assign pwrite_o    = r_psel && w_head_write;
    assign paddr_o     = r_psel ? w_head_addr  : '0;
    assign pwdata_o    = r_psel ? w_head_wdata : '0;
    assign pstrb_o     = (r_psel && w_head_write) ? w_head_strb : '0;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_q
// Description : Randomised bench for apb_master_q against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_q;
    import apb_pkg::*;

    localparam int c_ADDR_W  = 32;
    localparam int c_DATA_W  = 32;
    localparam int c_DEPTH   = 4;
    localparam int c_TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   cmd_valid_i;
    logic                   cmd_ready_o;
    logic                   cmd_write_i;
    logic [c_ADDR_W-1:0]    cmd_addr_i;
    logic [c_DATA_W-1:0]    cmd_wdata_i;
    logic [c_DATA_W/8-1:0]  cmd_strb_i;
    logic                   rsp_valid_o;
    logic [c_DATA_W-1:0]    rsp_rdata_o;
    logic                   rsp_err_o;
    logic                   psel_o;
    logic                   penable_o;
    logic                   pwrite_o;
    logic [c_ADDR_W-1:0]    paddr_o;
    logic [c_DATA_W-1:0]    pwdata_o;
    logic [c_DATA_W/8-1:0]  pstrb_o;
    logic                   pready_i;
    logic                   pslverr_i;
    logic [c_DATA_W-1:0]    prdata_i;

    apb_master_q #(
        .ADDR_W  (c_ADDR_W),
        .DATA_W  (c_DATA_W),
        .DEPTH   (c_DEPTH),
        .TIMEOUT (c_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_write_i (cmd_write_i),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_strb_i  (cmd_strb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .paddr_o     (paddr_o),
        .pwdata_o    (pwdata_o),
        .pstrb_o     (pstrb_o),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .prdata_i    (prdata_i)
    );

    always #5 clk = ~clk;

    // Reference model: pending command queue plus the bus phase of its head.
    apb_cmd_t       q[$];
    int             m_phase;          // 0 idle, 1 setup, 2 access
    int             m_waits;
    int             m_plan;           // ACCESS wait cycles before pready
    int             plan_q[$] = '{3, 0, 20, 1, 0, 20};
    bit             exp_rv;
    bit             exp_err;
    logic [31:0]    exp_rdata;
    int             dir_n;
    int             n_checks;
    int             n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick_plan();
        if (plan_q.size() > 0) return plan_q.pop_front();
        if ($urandom_range(0, 7) == 0) return 20;
        return int'($urandom_range(0, 4));
    endfunction

    task automatic check_outputs();
        apb_cmd_t h;
        h = (m_phase != 0) ? q[0] : '0;
        check("cmd_ready", cmd_ready_o, q.size() < c_DEPTH);
        check("psel", psel_o, m_phase != 0);
        check("penable", penable_o, m_phase == 2);
        check("pwrite", pwrite_o, h.write);
        check("paddr", paddr_o, h.addr);
        check("pwdata", pwdata_o, h.wdata);
        check("pstrb", pstrb_o, h.write ? h.strb : 4'h0);
        check("rsp_valid", rsp_valid_o, exp_rv);
        if (exp_rv) begin
            check("rsp_err", rsp_err_o, exp_err);
            check("rsp_rdata", rsp_rdata_o, exp_rdata);
        end
    endtask

    // Called at a falling edge: check, drive the next cycle, advance the model.
    task automatic step(input int push_pct);
        bit       accept;
        bit       done;
        apb_cmd_t c;
        check_outputs();
        c.write = 1'($urandom_range(0, 1));
        c.addr  = $urandom;
        c.wdata = $urandom;
        c.strb  = 4'($urandom);
        cmd_valid_i = ($urandom_range(0, 99) < push_pct);
        if (dir_n == 0) begin
            c = '{write: 1'b0, addr: 32'hDEAD_CAFE, wdata: 32'h0, strb: 4'h0};
            cmd_valid_i = 1'b1;
        end else if (dir_n == 1) begin
            c = '{write: 1'b1, addr: 32'hDEAD_CAFE, wdata: 32'h6, strb: 4'hF};
            cmd_valid_i = 1'b1;
        end
        cmd_write_i = c.write;
        cmd_addr_i  = c.addr;
        cmd_wdata_i = c.wdata;
        cmd_strb_i  = c.strb;
        pslverr_i   = ($urandom_range(0, 3) == 0);
        prdata_i    = (dir_n <= 1) ? 32'h5 : $urandom;
        pready_i    = (m_phase == 2) ? (m_waits == m_plan) : 1'($urandom_range(0, 1));

        accept = cmd_valid_i && (q.size() < c_DEPTH);
        exp_rv = 1'b0;
        case (m_phase)
            0: if (q.size() > 0) begin
                m_phase = 1;
                m_plan  = pick_plan();
            end
            1: begin
                m_phase = 2;
                m_waits = 0;
            end
            default: begin
                done = pready_i || (m_waits == c_TIMEOUT - 1);
                if (done) begin
                    exp_rv    = 1'b1;
                    exp_err   = !pready_i || pslverr_i;
                    exp_rdata = (pready_i && !pslverr_i && !q[0].write) ? prdata_i : 32'h0;
                    void'(q.pop_front());
                    if (pready_i && (q.size() > 0 || accept)) begin
                        m_phase = 1;
                        m_plan  = pick_plan();
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_waits++;
                end
            end
        endcase
        if (accept) begin
            q.push_back(c);
            dir_n++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0;
        m_waits = 0;
        exp_rv  = 1'b0;
    endtask

    initial begin
        int guard;
        n_checks    = 0;
        n_fail      = 0;
        dir_n       = 0;
        reset       = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'b0;
        cmd_addr_i  = '0;
        cmd_wdata_i = '0;
        cmd_strb_i  = '0;
        pready_i    = 1'b0;
        pslverr_i   = 1'b0;
        prdata_i    = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        reset = 1'b0;

        repeat (300) step(30);
        repeat (300) step(90);

        // Reset while a transfer is in ACCESS with further commands queued.
        guard = 0;
        while (!(m_phase == 2 && q.size() >= 3) && guard < 2000) begin
            step(95);
            guard++;
        end
        check("reset_scenario_reached", guard < 2000, 1'b1);
        check_outputs();
        cmd_valid_i = 1'b0;
        pready_i    = 1'b0;
        reset       = 1'b1;
        #1;
        check("rst_psel", psel_o, 1'b0);
        check("rst_penable", penable_o, 1'b0);
        check("rst_ready", cmd_ready_o, 1'b1);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        model_reset();
        @(negedge clk);
        check_outputs();
        reset = 1'b0;

        repeat (300) step(60);
        repeat (80) step(0);
        check("drained_psel", psel_o, 1'b0);
        check("drained_ready", cmd_ready_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
